// File: rtl/exu_mc.sv
// Multi-cycle execute unit: reads operands through one sync register-file port,
// runs ALU/load/store/jal/ebreak work and writes back with next-PC reporting.
module exu_mc #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RADDR_W     = 5,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic                 use_imm,
    input  logic [1:0]           mem_size,
    input  logic                 mem_unsigned,
    input  logic [RADDR_W-1:0]   rs1,
    input  logic [RADDR_W-1:0]   rs2,
    input  logic [RADDR_W-1:0]   rd,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      pc,
    output logic                 reg_ren,
    output logic [RADDR_W-1:0]   reg_raddr,
    input  logic [XLEN-1:0]      reg_rdata,
    output logic                 reg_wen,
    output logic [RADDR_W-1:0]   reg_waddr,
    output logic [XLEN-1:0]      reg_wdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [XLEN/8-1:0]    mem_wmask,
    input  logic                 mem_ack,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 out_valid,
    output logic [XLEN-1:0]      next_pc,
    output logic                 halt,
    output logic                 ebreak
);
    localparam int unsigned SH_W  = $clog2(XLEN);
    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned LB    = $clog2(NB);
    localparam int unsigned TMO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_SLL = 4'd5,  OP_SRL = 4'd6,  OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8,  OP_SLTU = 4'd9, OP_LOAD = 4'd10, OP_STORE = 4'd11;
    localparam logic [3:0] OP_JAL = 4'd12, OP_EBREAK = 4'd13;

    typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_EXEC, S_MEM, S_WB, S_STOP} state_t;

    state_t             state;
    logic [3:0]         op_q;
    logic               use_imm_q;
    logic [1:0]         size_q;
    logic               mem_unsigned_q;
    logic [RADDR_W-1:0] rs2_q;
    logic [RADDR_W-1:0] rd_q;
    logic [XLEN-1:0]    imm_q;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    src1;
    logic [XLEN-1:0]    src2;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [XLEN-1:0]    src2_c, b_c, addr_c, alu_c, st_data_c, lane_c, ld_shl_c, ld_c;
    logic [SH_W-1:0]    sh_c, ext_sh_c;
    logic [2:0]         amask_c;
    logic               misalign_c, size_ok_c, tmo_hit_c;
    logic [NB-1:0]      wmask_base_c, wmask_c;

    // src2 is captured at the end of EXEC, so EXEC itself reads the port directly
    always_comb begin
        src2_c  = (state == S_EXEC) ? reg_rdata : src2;
        b_c     = use_imm_q ? imm_q : src2_c;
        sh_c    = b_c[SH_W-1:0];
        addr_c  = src1 + imm_q;
        alu_c   = '0;
        case (op_q)
            OP_ADD:  alu_c = src1 + b_c;
            OP_SUB:  alu_c = src1 - b_c;
            OP_AND:  alu_c = src1 & b_c;
            OP_OR:   alu_c = src1 | b_c;
            OP_XOR:  alu_c = src1 ^ b_c;
            OP_SLL:  alu_c = src1 << sh_c;
            OP_SRL:  alu_c = src1 >> sh_c;
            OP_SRA:  alu_c = XLEN'($signed(src1) >>> sh_c);
            OP_SLT:  alu_c = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(b_c)};
            OP_SLTU: alu_c = {{(XLEN-1){1'b0}}, src1 < b_c};
            default: alu_c = '0;
        endcase

        amask_c      = 3'b111;
        wmask_base_c = NB'(8'hFF);
        st_data_c    = src2_c;
        ext_sh_c     = '0;
        case (size_q)
            2'd0: begin
                amask_c      = 3'b000;
                wmask_base_c = NB'(8'h01);
                st_data_c    = {NB{src2_c[7:0]}};
                ext_sh_c     = SH_W'(XLEN - 8);
            end
            2'd1: begin
                amask_c      = 3'b001;
                wmask_base_c = NB'(8'h03);
                st_data_c    = {(NB/2){src2_c[15:0]}};
                ext_sh_c     = SH_W'(XLEN - 16);
            end
            2'd2: begin
                amask_c      = 3'b011;
                wmask_base_c = NB'(8'h0F);
                st_data_c    = {(NB/4){src2_c[31:0]}};
                ext_sh_c     = SH_W'(XLEN - 32);
            end
            default: ;
        endcase
        misalign_c = |(addr_c[2:0] & amask_c);
        size_ok_c  = (XLEN == 64) || (size_q != 2'd3);
        wmask_c    = wmask_base_c << addr_c[LB-1:0];

        // Load lane: shift down to bit 0, then left-justify and shift back to extend
        lane_c   = mem_rdata >> {mem_addr[LB-1:0], 3'b000};
        ld_shl_c = lane_c << ext_sh_c;
        ld_c     = mem_unsigned_q ? (ld_shl_c >> ext_sh_c)
                                  : XLEN'($signed(ld_shl_c) >>> ext_sh_c);
        tmo_hit_c = (MEM_TIMEOUT != 0) && ((32'(tmo_cnt) + 32'd1) == MEM_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            in_ready       <= 1'b1;
            op_q           <= '0;
            use_imm_q      <= 1'b0;
            size_q         <= '0;
            mem_unsigned_q <= 1'b0;
            rs2_q          <= '0;
            rd_q           <= '0;
            imm_q          <= '0;
            pc_q           <= '0;
            src1           <= '0;
            src2           <= '0;
            tmo_cnt        <= '0;
            reg_ren        <= 1'b0;
            reg_raddr      <= '0;
            reg_wen        <= 1'b0;
            reg_waddr      <= '0;
            reg_wdata      <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            out_valid      <= 1'b0;
            next_pc        <= '0;
            halt           <= 1'b0;
            ebreak         <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            reg_wen   <= 1'b0;
            case (state)
                S_IDLE: if (in_valid) begin
                    op_q           <= op;
                    use_imm_q      <= use_imm;
                    size_q         <= mem_size;
                    mem_unsigned_q <= mem_unsigned;
                    rs2_q          <= rs2;
                    rd_q           <= rd;
                    imm_q          <= imm;
                    pc_q           <= pc;
                    reg_ren        <= 1'b1;
                    reg_raddr      <= rs1;
                    in_ready       <= 1'b0;
                    state          <= S_RD1;
                end
                S_RD1: begin
                    reg_raddr <= rs2_q;
                    state     <= S_RD2;
                end
                S_RD2: begin
                    src1    <= reg_rdata;
                    reg_ren <= 1'b0;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    src2 <= reg_rdata;
                    if (op_q <= OP_SLTU || op_q == OP_JAL) begin
                        out_valid <= 1'b1;
                        reg_wen   <= (rd_q != '0);
                        reg_waddr <= rd_q;
                        reg_wdata <= (op_q == OP_JAL) ? pc_q + XLEN'(4) : alu_c;
                        next_pc   <= (op_q == OP_JAL) ? pc_q + imm_q : pc_q + XLEN'(4);
                        state     <= S_WB;
                    end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
                        if (!size_ok_c || misalign_c) begin
                            halt  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= (op_q == OP_STORE);
                            mem_addr  <= addr_c;
                            mem_wdata <= (op_q == OP_STORE) ? st_data_c : '0;
                            mem_wmask <= (op_q == OP_STORE) ? wmask_c : '0;
                            tmo_cnt   <= '0;
                            state     <= S_MEM;
                        end
                    end else if (op_q == OP_EBREAK) begin
                        ebreak <= 1'b1;
                        state  <= S_STOP;
                    end else begin
                        halt  <= 1'b1;
                        state <= S_STOP;
                    end
                end
                // Ack is checked before the timeout so a same-cycle ack still retires
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        out_valid <= 1'b1;
                        reg_wen   <= !mem_we && (rd_q != '0);
                        reg_waddr <= rd_q;
                        reg_wdata <= mem_we ? '0 : ld_c;
                        next_pc   <= pc_q + XLEN'(4);
                        state     <= S_WB;
                    end else if (tmo_hit_c) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        halt    <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_WB: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                S_STOP: begin
                    in_ready <= 1'b0;
                    reg_ren  <= 1'b0;
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
